uart_rx_to_axis: RTL and testbench
==================================

# uart_rx_to_axis

Receives asynchronous UART frames on a single serial line, checks start, parity and stop bits, and presents each received word as an AXI-Stream master beat. It is the receive-side counterpart of the team's AXIS-to-UART transmitter. Both blocks share the same parameter set, so a TX/RX pair configured identically interoperates. It sits between the board RX pin and any AXI-Stream consumer, such as a FIFO or command parser.

## Interface
Parameters:
- CLK_FREQ, 100, clock frequency in MHz
- BIT_RATE, 115200, line rate in bit/s
- BIT_PER_WORD, 8, data bits per frame, 5..8
- PARITY_BIT, 0, parity mode: 0 none, 1 odd, 2 even
- STOP_BITS_NUM, 1, stop bits: 1 or 2

Ports:
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- RX  in  1  UART serial input; idles high; asynchronous to aclk
- tdata  out  8  received word, LSB = first data bit; bits above BIT_PER_WORD-1 are 0
- tuser  out  2  status for the current beat: [0] parity error, [1] frame (stop-bit) error
- tvalid  out  1  AXI-Stream valid
- tready  in  1  AXI-Stream ready
- overrun  out  1  one-cycle pulse when a completed word is dropped

## Operation
- RX passes through a 2-flop synchronizer (reset value 1). Start detection uses a falling edge of the synchronized RX, i.e. previous sample 1, current sample 0.
- Bit period: P = CLK_FREQ*10^6/BIT_RATE, integer division. Half period: H = P/2. Clock counter is 18 bits, so P ≤ 262143.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: on a falling edge, clear the counter and go to START.
- START: at count H-1, sample RX.
  - If RX = 0, clear the counter and go to DATA.
  - If RX = 1 (glitch), go to IDLE with no output.
- DATA: sample at count P-1, which is mid-bit. Shift LSB-first into the shift register. Bit counter runs 0..BIT_PER_WORD-1. After the last bit, go to PARITY if PARITY_BIT≠0, else STOP1.
- PARITY: sample at P-1. Error conditions:
  - Odd mode: XOR of data and parity bit = 0.
  - Even mode: that XOR = 1.
- STOP1: sample at P-1. Sample = 0 sets the frame error.
  - STOP_BITS_NUM=1: frame complete, go to IDLE.
  - STOP_BITS_NUM=2: go to STOP2, which samples and checks the same way, then the frame is complete and the FSM goes to IDLE.
- The FSM returns to IDLE at mid-stop-bit, which gives half a bit of resync margin for the next start edge.
- Frame complete: the word and its {frame_err, parity_err} are delivered to the output register even when errors are flagged.
- Output register (single entry):
  - If tvalid=0, or tvalid=1 with tready=1 in the completion cycle: load tdata/tuser and set tvalid=1.
  - If tvalid=1 with tready=0: keep the old beat unchanged, drop the new word, pulse overrun.
- tvalid clears on the cycle after a tvalid&tready handshake, unless a new word loads in that same cycle.
- Break (RX held low): the frame completes with frame_err=1 and tdata=0. No new start is detected until RX returns high, because the falling-edge rule prevents it.

## Timing
- Reset values: tvalid=0, tdata=0, tuser=0, overrun=0, FSM=IDLE, counters=0, synchronizer=1. Reset asserted mid-frame aborts the frame and drops any pending beat.
- RX-to-decision latency: 2 cycles of synchronizer plus 1 cycle of edge register.
- tvalid rises 1 cycle after the final stop-bit sample, roughly (1 + BIT_PER_WORD + parity + stop − 0.5)·P cycles after the start edge.
- AXI-Stream rules: tdata/tuser are stable while tvalid=1 and tready=0. tvalid does not depend combinationally on tready.
- Back-to-back frames at full BIT_RATE with tready tied high produce no overrun.
- Sampling error tolerance: ±(H−3)/P relative to the ideal mid-bit position.

## Test plan
- Defaults (CPP=868). Send 0xA5 8N1 with tready=1. Expect: tdata=0xA5, tuser=0, one tvalid beat, overrun never pulses.
- PARITY_BIT=2. Send 0x03 with correct parity bit 0, then 0x03 with parity bit 1. Expect: tuser=00, then tuser=01.
- STOP_BITS_NUM=2. Send 0x5A with the second stop bit forced to 0. Expect: tdata=0x5A, tuser=10. Then a 1-cycle-wide-of-H low glitch on RX. Expect: no beat.
- tready=0. Send 0x11 then 0x22. Expect: tdata stays 0x11, overrun pulses once at the 0x22 completion. Raise tready: 0x11 accepted, tvalid drops.
- Assert aresetn=0 mid-DATA. Expect: all outputs return to reset values immediately. Release and send 0x7E. Expect: tdata=0x7E cleanly received.
- Loopback with the AXIS-to-UART transmitter at identical parameters (BIT_PER_WORD=7, odd parity). Send 256 random words. Expect: all received in order, tuser=0, no overrun.

Source files
------------

// File: rtl/uart_rx_to_axis.sv
// -----------------------------------------------------------------------------
// uart_rx_to_axis
//
// UART receiver with an AXI-Stream master output. A frame is one start bit,
// BIT_PER_WORD data bits (LSB first), an optional parity bit and one or two
// stop bits. Each completed frame becomes a single AXI-Stream beat, and any
// detected errors are reported in tuser. This block pairs with the AXIS-to-UART
// transmitter that uses the same parameter set.
//
// Parameters
//   CLK_FREQ       clock frequency in MHz
//   BIT_RATE       line rate in bit/s
//   BIT_PER_WORD   data bits per frame, 5..8
//   PARITY_BIT     0 none, 1 odd, 2 even
//   STOP_BITS_NUM  1 or 2
//
// Ports
//   aclk     clock, rising edge
//   aresetn  asynchronous active-low reset
//   RX       serial input, idles high, asynchronous to aclk
//   tdata    received word, zero above BIT_PER_WORD-1
//   tuser    [0] parity error, [1] frame (stop-bit) error
//   tvalid   beat valid
//   tready   beat accepted by the consumer
//   overrun  one-cycle pulse when a completed word is dropped
// -----------------------------------------------------------------------------
module uart_rx_to_axis #(
  parameter int unsigned CLK_FREQ      = 100,
  parameter int unsigned BIT_RATE      = 115200,
  parameter int unsigned BIT_PER_WORD  = 8,
  parameter int unsigned PARITY_BIT    = 0,
  parameter int unsigned STOP_BITS_NUM = 1
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       RX,
  output logic [7:0] tdata,
  output logic [1:0] tuser,
  output logic       tvalid,
  input  logic       tready,
  output logic       overrun
);

  // Clock cycles per bit, and the counter values at which bits are sampled.
  localparam int unsigned BIT_CYCLES = (CLK_FREQ * 32'd1000000) / BIT_RATE;
  localparam logic [17:0] BIT_LAST   = 18'(BIT_CYCLES - 1);
  localparam logic [17:0] HALF_LAST  = 18'(BIT_CYCLES / 2 - 1);
  localparam logic [2:0]  WORD_LAST  = 3'(BIT_PER_WORD - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  state_t      state_q, state_d;
  logic [17:0] cnt_q, cnt_d;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  data_q;
  logic        parity_err_q;
  logic        frame_err_q;

  logic rx_meta, rx_sync, rx_prev;
  logic fall;
  logic half_tick, bit_tick;
  logic frame_done;
  logic frame_err_now;

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge register. They reset to the idle (high) line
  // level so that leaving reset never looks like a start edge.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always written with non-blocking assignments, so
  // every flop samples the values from before the clock edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall      = rx_prev & ~rx_sync;
  assign half_tick = (cnt_q == HALF_LAST);
  assign bit_tick  = (cnt_q == BIT_LAST);

  // ---------------------------------------------------------------------------
  // Frame FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: next state, bit-period counter and completion strobe
  // ---------------------------------------------------------------------------
  // NOTE: each output of this block gets its default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fall) state_d = START;
      end
      START: begin
        // A line that is high again at mid-start was only a glitch.
        if (half_tick) state_d = rx_sync ? IDLE : DATA;
      end
      DATA: begin
        if (bit_tick && bit_cnt_q == WORD_LAST)
          state_d = (PARITY_BIT != 0) ? PARITY : STOP1;
      end
      PARITY: begin
        if (bit_tick) state_d = STOP1;
      end
      STOP1: begin
        if (bit_tick) begin
          if (STOP_BITS_NUM == 2) begin
            state_d = STOP2;
          end else begin
            state_d    = IDLE;
            frame_done = 1'b1;
          end
        end
      end
      STOP2: begin
        if (bit_tick) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The counter restarts on every state change and on every full bit period;
    // it stays at zero while idle so the start edge begins a fresh count.
    if (state_q == IDLE || state_d != state_q || bit_tick)
      cnt_d = '0;
    else
      cnt_d = cnt_q + 18'd1;
  end

  // ---------------------------------------------------------------------------
  // Datapath: word assembly and error flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bit_cnt_q    <= '0;
      data_q       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            bit_cnt_q    <= '0;
            data_q       <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
          end
        end
        DATA: begin
          // Bits land at their final position, so bits above the word stay 0.
          if (bit_tick) begin
            data_q[bit_cnt_q] <= rx_sync;
            bit_cnt_q         <= bit_cnt_q + 3'd1;
          end
        end
        PARITY: begin
          if (bit_tick) begin
            if (PARITY_BIT == 1)
              parity_err_q <= ~(^data_q ^ rx_sync);
            else
              parity_err_q <= ^data_q ^ rx_sync;
          end
        end
        STOP1, STOP2: begin
          if (bit_tick && !rx_sync) frame_err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The final stop sample is taken in the completion cycle itself, so it is
  // folded into the delivered status directly.
  assign frame_err_now = frame_err_q | ~rx_sync;

  // ---------------------------------------------------------------------------
  // Single-entry AXI-Stream output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tdata   <= '0;
      tuser   <= '0;
      tvalid  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_done) begin
        if (!tvalid || tready) begin
          tdata  <= data_q;
          tuser  <= {frame_err_now, parity_err_q};
          tvalid <= 1'b1;
        end else begin
          // The held beat has priority; the new word is lost.
          overrun <= 1'b1;
        end
      end else if (tvalid && tready) begin
        tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_to_axis.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_to_axis
//
// Three receivers with different frame formats share one clock and reset:
//   inst 0: 7 data bits, odd parity, 2 stop bits
//   inst 1: 8 data bits, even parity, 1 stop bit
//   inst 2: 8 data bits, no parity, 1 stop bit
// Every instance runs at 16 clocks per bit. Stimulus tasks build UART frames
// from a word and error-injection flags. Each task pushes the beat it expects
// into a per-instance queue. A monitor on the falling clock edge pops and
// compares each accepted beat, counts overrun pulses and checks that held
// beats stay stable.
// -----------------------------------------------------------------------------
module tb_uart_rx_to_axis;

  localparam int P = 16;
  localparam int H = P / 2;
  localparam int BPW   [3] = '{7, 8, 8};
  localparam int PAR   [3] = '{1, 2, 0};
  localparam int NSTOP [3] = '{2, 1, 1};

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] user;
  } beat_t;

  logic       clk = 1'b0;
  logic       aresetn;
  logic [2:0] rx;
  logic [2:0] tready;
  logic [7:0] tdata [3];
  logic [1:0] tuser [3];
  logic [2:0] tvalid;
  logic [2:0] overrun;

  always #5 clk = ~clk;

  uart_rx_to_axis #(
    .CLK_FREQ(1), .BIT_RATE(62500), .BIT_PER_WORD(BPW[0]),
    .PARITY_BIT(PAR[0]), .STOP_BITS_NUM(NSTOP[0])
  ) dut0 (
    .aclk(clk), .aresetn(aresetn), .RX(rx[0]), .tdata(tdata[0]), .tuser(tuser[0]),
    .tvalid(tvalid[0]), .tready(tready[0]), .overrun(overrun[0])
  );

  uart_rx_to_axis #(
    .CLK_FREQ(1), .BIT_RATE(62500), .BIT_PER_WORD(BPW[1]),
    .PARITY_BIT(PAR[1]), .STOP_BITS_NUM(NSTOP[1])
  ) dut1 (
    .aclk(clk), .aresetn(aresetn), .RX(rx[1]), .tdata(tdata[1]), .tuser(tuser[1]),
    .tvalid(tvalid[1]), .tready(tready[1]), .overrun(overrun[1])
  );

  uart_rx_to_axis #(
    .CLK_FREQ(1), .BIT_RATE(62500), .BIT_PER_WORD(BPW[2]),
    .PARITY_BIT(PAR[2]), .STOP_BITS_NUM(NSTOP[2])
  ) dut2 (
    .aclk(clk), .aresetn(aresetn), .RX(rx[2]), .tdata(tdata[2]), .tuser(tuser[2]),
    .tvalid(tvalid[2]), .tready(tready[2]), .overrun(overrun[2])
  );

  int    tests = 0;
  int    fails = 0;
  beat_t exp_q [3][$];
  int    ovr_cnt [3];
  int    ovr_exp [3];
  bit    hold_prev [3];
  beat_t prev_beat [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    beat_t e;
    for (int k = 0; k < 3; k++) begin
      if (!aresetn) begin
        hold_prev[k] = 1'b0;
      end else begin
        if (overrun[k]) ovr_cnt[k]++;
        if (hold_prev[k])
          check($sformatf("hold%0d", k), {tvalid[k], tdata[k], tuser[k]}, {1'b1, prev_beat[k]});
        if (tvalid[k] && tready[k]) begin
          if (exp_q[k].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL beat%0d: unexpected beat data 0x%0h user %0b, none expected",
                     k, tdata[k], tuser[k]);
          end else begin
            e = exp_q[k].pop_front();
            check($sformatf("beat%0d", k), {tdata[k], tuser[k]}, e);
          end
        end
        hold_prev[k] = tvalid[k] && !tready[k];
        prev_beat[k] = {tdata[k], tuser[k]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic drive_bit(input int k, input logic b);
    rx[k] = b;
    repeat (P) @(posedge clk);
    #1;
  endtask

  // Builds one frame from the word and error flags, and pushes the beat that
  // the frame should produce when push is set.
  task automatic send_frame(input int k, input logic [7:0] w, input bit bad_par,
                            input bit [1:0] bad_stop, input bit push);
    logic [7:0] d;
    logic       pbit;
    logic [1:0] stop_mask;
    beat_t      e;
    d         = w & (8'hFF >> (8 - BPW[k]));
    stop_mask = (NSTOP[k] == 2) ? 2'b11 : 2'b01;
    e.data    = d;
    e.user    = {|(bad_stop & stop_mask), (PAR[k] != 0) && bad_par};
    if (push) exp_q[k].push_back(e);
    drive_bit(k, 1'b0);
    for (int i = 0; i < BPW[k]; i++) drive_bit(k, w[i]);
    if (PAR[k] != 0) begin
      // Odd mode: data plus parity carries an odd number of ones.
      pbit = (PAR[k] == 1) ? ~(^d) : ^d;
      drive_bit(k, pbit ^ bad_par);
    end
    for (int s = 0; s < NSTOP[k]; s++) drive_bit(k, ~bad_stop[s]);
    rx[k] = 1'b1;
  endtask

  task automatic random_stream(input int k, input int n);
    logic [7:0] w;
    bit         bp;
    bit [1:0]   bs;
    int         gap;
    for (int i = 0; i < n; i++) begin
      w   = 8'($urandom);
      bp  = ($urandom_range(0, 7) == 0);
      bs  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      send_frame(k, w, bp, bs, 1'b1);
      gap = int'($urandom_range(0, 1));
      // A low final stop bit needs idle time before the next start edge.
      if (bs[NSTOP[k]-1]) gap = 1;
      repeat (gap) drive_bit(k, 1'b1);
    end
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("%s_left%0d", tag, k), exp_q[k].size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_tvalid%0d", tag, k), tvalid[k], 0);
      check($sformatf("%s_tdata%0d", tag, k), tdata[k], 0);
      check($sformatf("%s_tuser%0d", tag, k), tuser[k], 0);
      check($sformatf("%s_overrun%0d", tag, k), overrun[k], 0);
    end
  endtask

  // Watchdog: the full run is far shorter than this.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    for (int k = 0; k < 3; k++) begin
      ovr_cnt[k]   = 0;
      ovr_exp[k]   = 0;
      hold_prev[k] = 1'b0;
      prev_beat[k] = '0;
    end
    aresetn = 1'b0;
    rx      = 3'b111;
    tready  = 3'b111;
    repeat (5) @(posedge clk);
    #1;
    check_reset_values("rst");
    aresetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Directed frames: clean 8N1, even parity good/bad, 2-stop with bad stop.
    fork
      send_frame(2, 8'hA5, 1'b0, 2'b00, 1'b1);
      begin
        send_frame(1, 8'h03, 1'b0, 2'b00, 1'b1);
        drive_bit(1, 1'b1);
        send_frame(1, 8'h03, 1'b1, 2'b00, 1'b1);
      end
      send_frame(0, 8'h5A, 1'b0, 2'b10, 1'b1);
    join
    drive_bit(0, 1'b1);
    wait_drain(4 * P, "dir");

    // Short low glitches on RX must not produce a beat.
    rx[0] = 1'b0;
    @(posedge clk);
    #1;
    rx[0] = 1'b1;
    repeat (3 * P) @(posedge clk);
    #1;
    rx[0] = 1'b0;
    repeat (H - 3) @(posedge clk);
    #1;
    rx[0] = 1'b1;
    repeat (20 * P) @(posedge clk);
    #1;
    check("glitch_tvalid", tvalid[0], 0);

    // Backpressure: second word is dropped with one overrun pulse.
    tready[1] = 1'b0;
    send_frame(1, 8'h11, 1'b0, 2'b00, 1'b1);
    send_frame(1, 8'h22, 1'b0, 2'b00, 1'b0);
    ovr_exp[1] = 1;
    drive_bit(1, 1'b1);
    check("bp_tvalid", tvalid[1], 1);
    check("bp_tdata", tdata[1], 8'h11);
    check("bp_overrun", ovr_cnt[1], 1);
    tready[1] = 1'b1;
    wait_drain(4 * P, "bp");
    repeat (2) @(posedge clk);
    #1;
    check("bp_tvalid_drop", tvalid[1], 0);

    // Break: line held low gives a zero word with a frame error, once.
    exp_q[2].push_back('{data: 8'h00, user: 2'b10});
    rx[2] = 1'b0;
    repeat (14 * P) @(posedge clk);
    #1;
    rx[2] = 1'b1;
    repeat (2 * P) @(posedge clk);
    #1;
    wait_drain(4 * P, "brk");

    // Reset mid-frame, with a beat held on instance 0.
    tready[0] = 1'b0;
    send_frame(0, 8'h3C, 1'b0, 2'b00, 1'b0);
    drive_bit(0, 1'b1);
    check("pend_tvalid", tvalid[0], 1);
    drive_bit(2, 1'b0);
    drive_bit(2, 1'b1);
    drive_bit(2, 1'b0);
    drive_bit(2, 1'b1);
    aresetn = 1'b0;
    #1;
    check_reset_values("mid");
    rx[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    aresetn   = 1'b1;
    tready[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_frame(2, 8'h7E, 1'b0, 2'b00, 1'b1);
    drive_bit(2, 1'b1);
    wait_drain(4 * P, "post");

    // Randomized back-to-back traffic with occasional injected errors.
    fork
      random_stream(0, 60);
      random_stream(1, 60);
      random_stream(2, 60);
    join
    repeat (2) drive_bit(0, 1'b1);
    wait_drain(8 * P, "rand");

    for (int k = 0; k < 3; k++)
      check($sformatf("overrun_total%0d", k), ovr_cnt[k], ovr_exp[k]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
